// File: rtl/burst_pulse_gen.sv
// Burst pulse generator: emits Count single-cycle En pulses on channel Slt, separated by Gap idle cycles.
// Optional CH1_SCALE_EN: channel-1 bursts emit 4*Count pulses for downstream divide-by-4 counters.
module burst_pulse_gen #(
    parameter int CNT_W = 16,
    parameter int GAP_W = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [CNT_W-1:0]   Count,
    input  logic [GAP_W-1:0]   Gap,
    input  logic               Chan,
    input  logic               Abort,
    output logic               En,
    output logic               Slt,
    output logic               Busy,
    output logic               Done,
    output logic [CNT_W+1:0]   Remaining
);

    localparam int REM_W = CNT_W + 2;

    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [REM_W-1:0]   remaining_next;
    logic [GAP_W-1:0]   gap_reg;
    logic [GAP_W-1:0]   gap_reg_next;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_cnt_next;
    logic               chan_reg;
    logic               chan_next;
    logic               en_next;
    logic               busy_next;
    logic               done_next;
    logic               slt_next;
    logic               accept;
    logic [REM_W-1:0]   load_count;

    assign accept = Start && ((state == IDLE) || (state == DONE));

`ifdef CH1_SCALE_EN
    assign load_count = Chan ? {Count, 2'b00} : {2'b00, Count};
`else
    assign load_count = {2'b00, Count};
`endif

    // State and all outputs are registered together so every output is glitch-free.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            Remaining <= '0;
            gap_reg   <= '0;
            gap_cnt   <= '0;
            chan_reg  <= 1'b0;
            En        <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Slt       <= 1'b0;
        end else begin
            state     <= state_next;
            Remaining <= remaining_next;
            gap_reg   <= gap_reg_next;
            gap_cnt   <= gap_cnt_next;
            chan_reg  <= chan_next;
            En        <= en_next;
            Busy      <= busy_next;
            Done      <= done_next;
            Slt       <= slt_next;
        end
    end

    // Abort only matters while a burst is running; in IDLE/DONE a Start always wins.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = (load_count == '0) ? DONE : PULSE;
                else
                    state_next = IDLE;
            end
            PULSE: begin
                if (Abort)
                    state_next = IDLE;
                else if (Remaining == REM_W'(1))
                    state_next = DONE;
                else if (gap_reg == '0)
                    state_next = PULSE;
                else
                    state_next = GAP;
            end
            GAP: begin
                if (Abort)
                    state_next = IDLE;
                else if (gap_cnt == GAP_W'(1))
                    state_next = PULSE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath updates and next output values, decoded from the upcoming state.
    always_comb begin
        remaining_next = Remaining;
        gap_reg_next   = gap_reg;
        gap_cnt_next   = gap_cnt;
        chan_next      = chan_reg;
        if (accept) begin
            remaining_next = load_count;
            gap_reg_next   = Gap;
            chan_next      = Chan;
        end else if (state_next == IDLE) begin
            remaining_next = '0;
        end else if (state == PULSE) begin
            remaining_next = Remaining - REM_W'(1);
            gap_cnt_next   = gap_reg;
        end else if (state == GAP) begin
            gap_cnt_next   = gap_cnt - GAP_W'(1);
        end

        en_next   = (state_next == PULSE);
        busy_next = (state_next == PULSE) || (state_next == GAP);
        done_next = (state_next == DONE);
        slt_next  = busy_next ? chan_next : 1'b0;
    end

endmodule

// File: tb/tb_burst_pulse_gen.sv
// Directed self-checking bench for burst_pulse_gen (default build, CH1_SCALE_EN undefined).
module tb_burst_pulse_gen;

    localparam int CNT_W = 16;
    localparam int GAP_W = 8;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               Start = 1'b0;
    logic [CNT_W-1:0]   Count = '0;
    logic [GAP_W-1:0]   Gap = '0;
    logic               Chan = 1'b0;
    logic               Abort = 1'b0;
    logic               En;
    logic               Slt;
    logic               Busy;
    logic               Done;
    logic [CNT_W+1:0]   Remaining;

    int testsRun = 0;
    int testsFailed = 0;

    burst_pulse_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Count(Count), .Gap(Gap),
        .Chan(Chan), .Abort(Abort), .En(En), .Slt(Slt), .Busy(Busy),
        .Done(Done), .Remaining(Remaining)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Checks all outputs in the current cycle, then advances to the next negedge.
    task automatic expectCycle(input string tag, input logic en, input logic busy, input logic done,
                               input logic slt, input int rem);
        checkOutput({tag, ".En"}, 32'(En), 32'(en));
        checkOutput({tag, ".Busy"}, 32'(Busy), 32'(busy));
        checkOutput({tag, ".Done"}, 32'(Done), 32'(done));
        checkOutput({tag, ".Slt"}, 32'(Slt), 32'(slt));
        checkOutput({tag, ".Rem"}, 32'(Remaining), 32'(rem));
        @(negedge Clk);
    endtask

    // Presents a one-cycle Start; returns at the negedge of the first cycle after acceptance.
    task automatic applyStimulus(input int cnt, input int gap, input logic chan, input logic abort);
        Count = CNT_W'(cnt);
        Gap   = GAP_W'(gap);
        Chan  = chan;
        Start = 1'b1;
        Abort = abort;
        @(negedge Clk);
        Start = 1'b0;
        Abort = 1'b0;
    endtask

    initial begin
        int enCount, doneCount, busyCount, maxRem, cycles;
        logic firstOk;

        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        expectCycle("reset", 0, 0, 0, 0, 0);

        // Count=3, Gap=0, Chan=0: back-to-back pulses
        applyStimulus(3, 0, 1'b0, 1'b0);
        expectCycle("t1c1", 1, 1, 0, 0, 3);
        expectCycle("t1c2", 1, 1, 0, 0, 2);
        expectCycle("t1c3", 1, 1, 0, 0, 1);
        expectCycle("t1done", 0, 0, 1, 0, 0);
        expectCycle("t1idle", 0, 0, 0, 0, 0);

        // Count=2, Gap=2, Chan=1
        applyStimulus(2, 2, 1'b1, 1'b0);
        expectCycle("t2c1", 1, 1, 0, 1, 2);
        expectCycle("t2c2", 0, 1, 0, 1, 1);
        expectCycle("t2c3", 0, 1, 0, 1, 1);
        expectCycle("t2c4", 1, 1, 0, 1, 1);
        expectCycle("t2done", 0, 0, 1, 0, 0);
        expectCycle("t2idle", 0, 0, 0, 0, 0);

        // Count=0: Done only
        applyStimulus(0, 3, 1'b1, 1'b0);
        expectCycle("t3done", 0, 0, 1, 0, 0);
        expectCycle("t3idle", 0, 0, 0, 0, 0);

        // Count=5, Gap=1, abort during the 2nd pulse
        applyStimulus(5, 1, 1'b0, 1'b0);
        expectCycle("t4c1", 1, 1, 0, 0, 5);
        expectCycle("t4c2", 0, 1, 0, 0, 4);
        Abort = 1'b1;
        expectCycle("t4c3", 1, 1, 0, 0, 4);
        Abort = 1'b0;
        expectCycle("t4abort", 0, 0, 0, 0, 0);
        expectCycle("t4nodone", 0, 0, 0, 0, 0);

        // Abort on the final pulse suppresses Done
        applyStimulus(1, 0, 1'b0, 1'b0);
        Abort = 1'b1;
        expectCycle("abLast", 1, 1, 0, 0, 1);
        Abort = 1'b0;
        expectCycle("abLastNoDone", 0, 0, 0, 0, 0);

        // Start and Abort together while idle: Start wins
        applyStimulus(1, 0, 1'b1, 1'b1);
        expectCycle("startWins", 1, 1, 0, 1, 1);
        expectCycle("startWinsDone", 0, 0, 1, 0, 0);

        // Start ignored mid-burst
        applyStimulus(3, 1, 1'b1, 1'b0);
        expectCycle("t5c1", 1, 1, 0, 1, 3);
        Count = 16'd7;
        Gap   = 8'd0;
        Chan  = 1'b0;
        Start = 1'b1;
        expectCycle("t5c2", 0, 1, 0, 1, 2);
        Start = 1'b0;
        expectCycle("t5c3", 1, 1, 0, 1, 2);
        expectCycle("t5c4", 0, 1, 0, 1, 1);
        expectCycle("t5c5", 1, 1, 0, 1, 1);
        expectCycle("t5done", 0, 0, 1, 0, 0);
        expectCycle("t5idle", 0, 0, 0, 0, 0);

        // Start accepted in the DONE cycle
        applyStimulus(1, 0, 1'b0, 1'b0);
        expectCycle("dnC1", 1, 1, 0, 0, 1);
        checkOutput("dnDone", 32'(Done), 32'd1);
        Count = 16'd2;
        Gap   = 8'd0;
        Chan  = 1'b1;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        expectCycle("dnR1", 1, 1, 0, 1, 2);
        expectCycle("dnR2", 1, 1, 0, 1, 1);
        expectCycle("dnRdone", 0, 0, 1, 0, 0);

        // Reset mid-burst truncates silently
        applyStimulus(4, 0, 1'b1, 1'b0);
        expectCycle("rsC1", 1, 1, 0, 1, 4);
        Reset = 1'b1;
        expectCycle("rsC2", 1, 1, 0, 1, 3);
        Reset = 1'b0;
        expectCycle("rsAfter", 0, 0, 0, 0, 0);
        expectCycle("rsNoDone", 0, 0, 0, 0, 0);

        // Maximum count: 65535 consecutive pulses, one Done, no wrap
        applyStimulus(16'hFFFF, 0, 1'b0, 1'b0);
        firstOk   = (Remaining == 18'h0FFFF);
        enCount   = 0;
        doneCount = 0;
        busyCount = 0;
        maxRem    = 0;
        cycles    = 0;
        while (cycles < 70000 && doneCount == 0) begin
            if (En) enCount++;
            if (Busy) busyCount++;
            if (Done) doneCount++;
            if (int'(Remaining) > maxRem) maxRem = int'(Remaining);
            cycles++;
            @(negedge Clk);
        end
        if (Done) doneCount++;
        checkOutput("maxFirstRem", 32'(firstOk), 32'd1);
        checkOutput("maxEnCount", 32'(enCount), 32'd65535);
        checkOutput("maxBusyCount", 32'(busyCount), 32'd65535);
        checkOutput("maxDoneCount", 32'(doneCount), 32'd1);
        checkOutput("maxRemPeak", 32'(maxRem), 32'h0000FFFF);
        checkOutput("maxRemEnd", 32'(Remaining), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
